// File: rtl/apix_pkg.sv
// Shared APIX link definitions: frame geometry, sync word, CRC-8 and receiver state encoding.
// Used by both the transmitter and the receiver.
package apix_pkg;

    localparam int PIXEL_W    = 24;
    localparam int CRC_W      = 8;
    localparam int SYNC_W     = 8;
    localparam int FRAME_BITS = SYNC_W + PIXEL_W + CRC_W;

    localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;
    localparam logic [CRC_W-1:0]  CRC_POLY  = 8'h07;

    localparam int LOCK_GOOD = 2;
    localparam int ERR_LIMIT = 3;
    localparam int CNT_W     = 16;
    localparam int BITCNT_W  = 5;
    localparam int RUN_W     = 2;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        RXCRC   = 2'd2,
        SYNC    = 2'd3
    } apix_state_e;

    // One MSB-first step of CRC-8, init 0, no reflection, no final XOR.
    function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : {CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/apix_receiver_if.sv
// Pixel-side bundle of the APIX receiver: serial line in, pixel/status out.
// pixel_valid, crc_error and sync_error are single-cycle strobes with no backpressure.
interface apix_receiver_if;
    import apix_pkg::*;

    logic               apix_data;
    logic [PIXEL_W-1:0] pixel_data;
    logic               pixel_valid;
    logic               crc_error;
    logic               sync_error;
    logic               link_locked;
    logic [CNT_W-1:0]   good_count;
    logic [CNT_W-1:0]   err_count;
    apix_state_e        dbg_state;

    modport master (
        output apix_data,
        input  pixel_data, pixel_valid, crc_error, sync_error,
        input  link_locked, good_count, err_count, dbg_state
    );

    modport slave (
        input  apix_data,
        output pixel_data, pixel_valid, crc_error, sync_error,
        output link_locked, good_count, err_count, dbg_state
    );

endinterface

// File: rtl/apix_crc8_serial.sv
// Bit-serial CRC-8 accumulator; clr wins over en.
module apix_crc8_serial
    import apix_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clr) begin
            crc_q <= '0;
        end else if (en) begin
            crc_q <= crc8_step(crc_q, bit_in);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/apix_receiver.sv
// APIX link receiver: sync hunt, 24-bit pixel deserialisation, CRC-8 check,
// lock qualification and saturating frame statistics.
module apix_receiver
    import apix_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    apix_receiver_if.slave  bus
);

    apix_state_e         state_q, state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [SYNC_W-1:0]   sh_q, sh_d, sh_next;
    logic [PIXEL_W-1:0]  pix_sh_q, pix_sh_d;
    logic [PIXEL_W-1:0]  pixel_q, pixel_d;
    logic                valid_q, valid_d;
    logic                crc_err_q, crc_err_d;
    logic                sync_err_q, sync_err_d;
    logic                lock_q, lock_d;
    logic [RUN_W-1:0]    good_run_q, good_run_d;
    logic [RUN_W-1:0]    bad_run_q, bad_run_d;
    logic [CNT_W-1:0]    good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
    logic                crc_clr, crc_en;
    logic [CRC_W-1:0]    crc_val;

    apix_crc8_serial u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (bus.apix_data),
        .crc    (crc_val)
    );

    // The window always includes the bit sampled on this edge.
    assign sh_next = {sh_q[SYNC_W-2:0], bus.apix_data};

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        sh_d       = sh_q;
        pix_sh_d   = pix_sh_q;
        pixel_d    = pixel_q;
        valid_d    = 1'b0;
        crc_err_d  = 1'b0;
        sync_err_d = 1'b0;
        lock_d     = lock_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        good_cnt_d = good_cnt_q;
        err_cnt_d  = err_cnt_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            HUNT: begin
                sh_d = sh_next;
                if (sh_next == SYNC_WORD) begin
                    state_d  = PAYLOAD;
                    bitcnt_d = '0;
                    sh_d     = '0;
                    crc_clr  = 1'b1;
                end
            end
            PAYLOAD: begin
                pix_sh_d = {pix_sh_q[PIXEL_W-2:0], bus.apix_data};
                crc_en   = 1'b1;
                sh_d     = '0;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BITCNT_W'(PIXEL_W - 1)) begin
                    state_d  = RXCRC;
                    bitcnt_d = '0;
                end
            end
            RXCRC: begin
                sh_d     = sh_next;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BITCNT_W'(CRC_W - 1)) begin
                    bitcnt_d = '0;
                    sh_d     = '0;
                    if (sh_next == crc_val) begin
                        pixel_d   = pix_sh_q;
                        valid_d   = 1'b1;
                        bad_run_d = '0;
                        if (good_run_q != RUN_W'(LOCK_GOOD)) good_run_d = good_run_q + 1'b1;
                        if (good_run_d == RUN_W'(LOCK_GOOD)) lock_d = 1'b1;
                    end else begin
                        crc_err_d  = 1'b1;
                        good_run_d = '0;
                        if (bad_run_q != RUN_W'(ERR_LIMIT)) bad_run_d = bad_run_q + 1'b1;
                        if (bad_run_d == RUN_W'(ERR_LIMIT)) lock_d = 1'b0;
                    end
                    state_d = lock_d ? SYNC : HUNT;
                end
            end
            SYNC: begin
                // Locked: the sync word must sit exactly where the previous frame ended.
                sh_d     = sh_next;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == BITCNT_W'(SYNC_W - 1)) begin
                    bitcnt_d = '0;
                    sh_d     = '0;
                    if (sh_next == SYNC_WORD) begin
                        state_d = PAYLOAD;
                        crc_clr = 1'b1;
                    end else begin
                        sync_err_d = 1'b1;
                        lock_d     = 1'b0;
                        good_run_d = '0;
                        bad_run_d  = '0;
                        state_d    = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        if (valid_d && (good_cnt_q != '1)) good_cnt_d = good_cnt_q + 1'b1;
        if ((crc_err_d || sync_err_d) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            bitcnt_q   <= '0;
            sh_q       <= '0;
            pix_sh_q   <= '0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            crc_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
            lock_q     <= 1'b0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            good_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            sh_q       <= sh_d;
            pix_sh_q   <= pix_sh_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            crc_err_q  <= crc_err_d;
            sync_err_q <= sync_err_d;
            lock_q     <= lock_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            good_cnt_q <= good_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.pixel_data  = pixel_q;
    assign bus.pixel_valid = valid_q;
    assign bus.crc_error   = crc_err_q;
    assign bus.sync_error  = sync_err_q;
    assign bus.link_locked = lock_q;
    assign bus.good_count  = good_cnt_q;
    assign bus.err_count   = err_cnt_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_apix_receiver.sv
// Bench for apix_receiver: directed frame scenarios plus random traffic, checked
// every cycle against a frame-level model of the link protocol.
module tb_apix_receiver;
    import apix_pkg::*;

    logic clk;
    logic rst_n;

    apix_receiver_if bus();

    apix_receiver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_valid_cyc = 0;

    // Model: bits received since the current hunt/frame/sync phase began.
    int          m_mode;      // 0 hunting, 1 collecting frame body, 2 collecting locked sync
    bit          m_q[$];
    logic [23:0] m_pixel;
    logic        m_valid, m_cerr, m_serr, m_lock;
    int          m_good_run, m_bad_run, m_good_cnt, m_err_cnt;

    // Remainder of pixel(x) * x^8 modulo x^8+x^2+x+1, by long division.
    function automatic logic [7:0] crc8(input logic [23:0] d);
        logic [31:0] v;
        v = {d, 8'h00};
        for (int i = 31; i >= 8; i--) begin
            if (v[i]) v = v ^ (32'h107 << (i - 8));
        end
        return v[7:0];
    endfunction

    function automatic int q_val(input int start, input int n);
        int r;
        r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | int'(m_q[start + i]);
        return r;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_q.delete();
        m_pixel = '0;
        m_valid = 0; m_cerr = 0; m_serr = 0; m_lock = 0;
        m_good_run = 0; m_bad_run = 0; m_good_cnt = 0; m_err_cnt = 0;
    endtask

    task automatic model_step(input bit b);
        logic [23:0] pix;
        logic [7:0]  rx;
        m_valid = 0; m_cerr = 0; m_serr = 0;
        m_q.push_back(b);
        case (m_mode)
            0: begin
                if (m_q.size() > 8) void'(m_q.pop_front());
                if (m_q.size() == 8 && q_val(0, 8) == 32'hA5) begin
                    m_mode = 1;
                    m_q.delete();
                end
            end
            1: begin
                if (m_q.size() == 32) begin
                    pix = 24'(q_val(0, 24));
                    rx  = 8'(q_val(24, 8));
                    if (crc8(pix) == rx) begin
                        m_pixel = pix;
                        m_valid = 1;
                        m_good_run++;
                        m_bad_run = 0;
                        if (m_good_cnt < 65535) m_good_cnt++;
                        if (m_good_run >= LOCK_GOOD) m_lock = 1;
                    end else begin
                        m_cerr = 1;
                        m_bad_run++;
                        m_good_run = 0;
                        if (m_err_cnt < 65535) m_err_cnt++;
                        if (m_bad_run >= ERR_LIMIT) m_lock = 0;
                    end
                    m_q.delete();
                    m_mode = m_lock ? 2 : 0;
                end
            end
            default: begin
                if (m_q.size() == 8) begin
                    if (q_val(0, 8) == 32'hA5) begin
                        m_mode = 1;
                    end else begin
                        m_serr = 1;
                        m_lock = 0;
                        m_good_run = 0;
                        m_bad_run = 0;
                        if (m_err_cnt < 65535) m_err_cnt++;
                        m_mode = 0;
                    end
                    m_q.delete();
                end
            end
        endcase
    endtask

    task automatic compare_all();
        cyc++;
        vectors++;
        if (bus.pixel_valid) last_valid_cyc = cyc;
        if (bus.pixel_data !== m_pixel || bus.pixel_valid !== m_valid ||
            bus.crc_error !== m_cerr || bus.sync_error !== m_serr ||
            bus.link_locked !== m_lock || bus.good_count !== 16'(m_good_cnt) ||
            bus.err_count !== 16'(m_err_cnt)) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got pix=%h v=%b ce=%b se=%b lk=%b gc=%0d ec=%0d, want pix=%h v=%b ce=%b se=%b lk=%b gc=%0d ec=%0d",
                     cyc, bus.pixel_data, bus.pixel_valid, bus.crc_error, bus.sync_error,
                     bus.link_locked, bus.good_count, bus.err_count,
                     m_pixel, m_valid, m_cerr, m_serr, m_lock, m_good_cnt, m_err_cnt);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge, right after the outputs are compared.
    task automatic send_bit(input bit b);
        bus.apix_data = b;
        @(posedge clk);
        if (rst_n) model_step(b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_frame(input logic [23:0] pix, input logic [7:0] flip, input logic [7:0] sync);
        logic [7:0] c;
        c = crc8(pix) ^ flip;
        send_byte(sync);
        for (int i = 23; i >= 0; i--) send_bit(pix[i]);
        send_byte(c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_immediate_outputs",
              {bus.pixel_valid, bus.crc_error, bus.sync_error, bus.link_locked, 28'(bus.pixel_data)},
              32'h0);
        check("rst_immediate_counts", {bus.good_count, bus.err_count}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        rst_n = 1'b1;
    endtask

    int t_a;
    int kind;
    logic [7:0] bad_sync;

    initial begin
        rst_n = 1'b0;
        bus.apix_data = 1'b0;
        model_reset();

        check("crc8_of_000001", 32'(crc8(24'h000001)), 32'h07);
        check("crc8_of_000080", 32'(crc8(24'h000080)), 32'h89);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compare_all();
        end
        check("reset_state", 32'(bus.dbg_state), 32'(HUNT));
        rst_n = 1'b1;

        // Single good frame.
        idle(3);
        send_frame(24'hABCDEF, 8'h00, SYNC_WORD);
        check("t1_valid", 32'(bus.pixel_valid), 32'h1);
        check("t1_pixel", 32'(bus.pixel_data), 32'h00ABCDEF);
        check("t1_good_count", 32'(bus.good_count), 32'h1);
        check("t1_locked", 32'(bus.link_locked), 32'h0);
        send_bit(1'b0);
        check("t1_valid_one_cycle", 32'(bus.pixel_valid), 32'h0);

        // Two back-to-back frames reach lock.
        reset_pulse();
        idle(2);
        send_frame(24'hABCDEF, 8'h00, SYNC_WORD);
        t_a = last_valid_cyc;
        send_frame(24'h123456, 8'h00, SYNC_WORD);
        check("t2_valid", 32'(bus.pixel_valid), 32'h1);
        check("t2_locked", 32'(bus.link_locked), 32'h1);
        check("t2_spacing", 32'(last_valid_cyc - t_a), 32'd40);

        // CRC errors while locked.
        send_frame(24'h777777, 8'h08, SYNC_WORD);
        check("t3_crc_error", 32'(bus.crc_error), 32'h1);
        check("t3_pixel_held", 32'(bus.pixel_data), 32'h00123456);
        check("t3_err_count", 32'(bus.err_count), 32'h1);
        check("t3_lock_held", 32'(bus.link_locked), 32'h1);
        send_frame(24'h111111, 8'h08, SYNC_WORD);
        send_frame(24'h222222, 8'h08, SYNC_WORD);
        check("t3_unlocked", 32'(bus.link_locked), 32'h0);
        check("t3_err_count3", 32'(bus.err_count), 32'h3);

        // Sync miss while locked.
        send_frame(24'h2468AC, 8'h00, SYNC_WORD);
        send_frame(24'h13579B, 8'h00, SYNC_WORD);
        check("t4_relocked", 32'(bus.link_locked), 32'h1);
        send_byte(8'hA4);
        check("t4_sync_error", 32'(bus.sync_error), 32'h1);
        check("t4_unlocked", 32'(bus.link_locked), 32'h0);
        check("t4_state_hunt", 32'(bus.dbg_state), 32'(HUNT));
        send_frame(24'hFEDCBA, 8'h00, SYNC_WORD);
        check("t4_after_valid", 32'(bus.pixel_valid), 32'h1);
        check("t4_after_pixel", 32'(bus.pixel_data), 32'h00FEDCBA);

        // Noise carrying false sync words, then a clean frame after the debris clears.
        idle(10);
        send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'hA5);
        send_frame(24'h5A5A5A, 8'h00, SYNC_WORD);
        idle(48);
        send_frame(24'h0F1E2D, 8'h00, SYNC_WORD);
        check("t5_valid", 32'(bus.pixel_valid), 32'h1);
        check("t5_pixel", 32'(bus.pixel_data), 32'h000F1E2D);

        // Reset at payload bit 10.
        idle(4);
        send_byte(SYNC_WORD);
        begin
            logic [23:0] p;
            p = 24'hC0FFEE;
            for (int i = 23; i > 13; i--) send_bit(p[i]);
        end
        reset_pulse();
        send_frame(24'hC0FFEE, 8'h00, SYNC_WORD);
        check("t6_valid", 32'(bus.pixel_valid), 32'h1);
        check("t6_pixel", 32'(bus.pixel_data), 32'h00C0FFEE);
        check("t6_good_count", 32'(bus.good_count), 32'h1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                send_frame(24'($urandom), 8'h00, SYNC_WORD);
            end else if (kind == 6) begin
                send_frame(24'($urandom), 8'(1 << $urandom_range(0, 7)), SYNC_WORD);
            end else if (kind == 7) begin
                bad_sync = SYNC_WORD ^ 8'(1 << $urandom_range(0, 7));
                send_frame(24'($urandom), 8'h00, bad_sync);
            end else if (kind == 8) begin
                idle($urandom_range(1, 12));
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 20)); i++) send_bit(1'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
